// File: rtl/dmi_stub_pkg.sv
// Shared types for the DMI register stub: request opcodes, response status
// codes and the transaction FSM states.
package dmi_stub_pkg;

   typedef enum logic [1:0] {
      OP_NOP   = 2'd0,
      OP_READ  = 2'd1,
      OP_WRITE = 2'd2,
      OP_RSVD  = 2'd3
   } op_e;

   typedef enum logic [1:0] {
      STATUS_OK     = 2'd0,
      STATUS_FAILED = 2'd2
   } status_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_e;

endpackage

// File: rtl/dmi_stub_regfile.sv
// Register storage for the DMI stub: one write port, one combinational read
// port, and every register exposed flat on regs_o.
module dmi_stub_regfile #(
   parameter int          DATA_W    = 32,
   parameter int          NUM_REGS  = 4,
   parameter logic [63:0] RESET_VAL = 64'd10,
   parameter int          IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         we_i,
   input  logic [IDX_W-1:0]             waddr_i,
   input  logic [DATA_W-1:0]            wdata_i,
   input  logic [IDX_W-1:0]             raddr_i,
   output logic [DATA_W-1:0]            rdata_o,
   output logic [NUM_REGS*DATA_W-1:0]   regs_o
);

   localparam logic [DATA_W-1:0] RST_VAL = RESET_VAL[DATA_W-1:0];

   logic [DATA_W-1:0] mem_reg [NUM_REGS];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
               mem_reg[gi] <= RST_VAL;
            end else if (we_i && (waddr_i == IDX_W'(gi))) begin
               mem_reg[gi] <= wdata_i;
            end
         end
         assign regs_o[gi*DATA_W +: DATA_W] = mem_reg[gi];
      end
   endgenerate

   // Explicit compare loop keeps non-power-of-two sizes from indexing past the array.
   always_comb begin
      rdata_o = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (raddr_i == IDX_W'(i)) begin
            rdata_o = mem_reg[i];
         end
      end
   end

endmodule

// File: rtl/dmi_stub.sv
// DMI register stub: accepts one request at a time, waits RSP_LAT idle cycles,
// then presents a held response until the requester takes it.
module dmi_stub
   import dmi_stub_pkg::*;
#(
   parameter int          DATA_W    = 32,
   parameter int          ADDR_W    = 7,
   parameter int          NUM_REGS  = 4,
   parameter logic [63:0] RESET_VAL = 64'd10,
   parameter int          RSP_LAT   = 1
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       req_valid_i,
   output logic                       req_ready_o,
   input  logic [1:0]                 req_op_i,
   input  logic [ADDR_W-1:0]          req_addr_i,
   input  logic [DATA_W-1:0]          req_data_i,
   output logic                       rsp_valid_o,
   input  logic                       rsp_ready_i,
   output logic [1:0]                 rsp_status_o,
   output logic [DATA_W-1:0]          rsp_data_o,
   output logic [NUM_REGS*DATA_W-1:0] regs_o
);

   localparam int              IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic [ADDR_W:0] NUM_REGS_W = (ADDR_W + 1)'(NUM_REGS);

   state_e            state_reg, state_next;
   logic [3:0]        cnt_reg, cnt_next;
   op_e               op_reg;
   logic [ADDR_W-1:0] addr_reg;
   logic [DATA_W-1:0] data_reg;
   status_e           status_reg;
   logic [DATA_W-1:0] rdata_reg;

   op_e               cur_op;
   logic [ADDR_W-1:0] cur_addr;
   logic [DATA_W-1:0] cur_data;
   logic              addr_ok;
   logic              enter_resp;
   logic              rsp_done;
   status_e           status_new;
   logic [DATA_W-1:0] rdata_new;
   logic [DATA_W-1:0] rf_rdata;
   logic              rf_we;

   // With zero latency RESP is entered on the accept edge, so the live request is used.
   assign cur_op   = (state_reg == ST_IDLE) ? op_e'(req_op_i) : op_reg;
   assign cur_addr = (state_reg == ST_IDLE) ? req_addr_i : addr_reg;
   assign cur_data = (state_reg == ST_IDLE) ? req_data_i : data_reg;
   assign addr_ok  = ({1'b0, cur_addr} < NUM_REGS_W);
   assign rsp_done = (state_reg == ST_RESP) && rsp_ready_i;
   assign rf_we    = enter_resp && (cur_op == OP_WRITE) && addr_ok;

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      enter_resp = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (req_valid_i) begin
               if (RSP_LAT == 0) begin
                  state_next = ST_RESP;
                  enter_resp = 1'b1;
               end else begin
                  state_next = ST_WAIT;
                  cnt_next   = 4'(RSP_LAT - 1);
               end
            end
         end
         ST_WAIT: begin
            if (cnt_reg == 4'd0) begin
               state_next = ST_RESP;
               enter_resp = 1'b1;
            end else begin
               cnt_next = cnt_reg - 4'd1;
            end
         end
         ST_RESP: begin
            if (rsp_ready_i) begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      status_new = STATUS_OK;
      rdata_new  = '0;
      if ((cur_op == OP_RSVD) || !addr_ok) begin
         status_new = STATUS_FAILED;
      end else if (cur_op == OP_READ) begin
         rdata_new = rf_rdata;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_reg  <= ST_IDLE;
         cnt_reg    <= 4'd0;
         op_reg     <= OP_NOP;
         addr_reg   <= '0;
         data_reg   <= '0;
         status_reg <= STATUS_OK;
         rdata_reg  <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         if ((state_reg == ST_IDLE) && req_valid_i) begin
            op_reg   <= op_e'(req_op_i);
            addr_reg <= req_addr_i;
            data_reg <= req_data_i;
         end
         if (enter_resp) begin
            status_reg <= status_new;
            rdata_reg  <= rdata_new;
         end else if (rsp_done) begin
            status_reg <= STATUS_OK;
            rdata_reg  <= '0;
         end
      end
   end

   assign req_ready_o  = (state_reg == ST_IDLE);
   assign rsp_valid_o  = (state_reg == ST_RESP);
   assign rsp_status_o = status_reg;
   assign rsp_data_o   = rdata_reg;

   dmi_stub_regfile #(
      .DATA_W    (DATA_W),
      .NUM_REGS  (NUM_REGS),
      .RESET_VAL (RESET_VAL),
      .IDX_W     (IDX_W)
   ) u_regfile (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .we_i    (rf_we),
      .waddr_i (cur_addr[IDX_W-1:0]),
      .wdata_i (cur_data),
      .raddr_i (cur_addr[IDX_W-1:0]),
      .rdata_o (rf_rdata),
      .regs_o  (regs_o)
   );

endmodule

// File: tb/tb_dmi_stub.sv
// Directed bench for dmi_stub: one instance with RSP_LAT=1, one with RSP_LAT=0.
module tb_dmi_stub;

   logic         clk;
   logic         rst_n;
   logic         req_valid, req_ready, rsp_valid, rsp_ready;
   logic [1:0]   req_op, rsp_status;
   logic [6:0]   req_addr;
   logic [31:0]  req_data, rsp_data;
   logic [127:0] regs;

   logic         z_req_valid, z_req_ready, z_rsp_valid, z_rsp_ready;
   logic [1:0]   z_req_op, z_rsp_status;
   logic [6:0]   z_req_addr;
   logic [31:0]  z_req_data, z_rsp_data;
   logic [127:0] z_regs;

   int checks = 0;
   int errors = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   dmi_stub #(.RSP_LAT(1)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .req_valid_i(req_valid), .req_ready_o(req_ready),
      .req_op_i(req_op), .req_addr_i(req_addr), .req_data_i(req_data),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
      .rsp_status_o(rsp_status), .rsp_data_o(rsp_data), .regs_o(regs)
   );

   dmi_stub #(.RSP_LAT(0)) dut0 (
      .clk_i(clk), .rst_ni(rst_n),
      .req_valid_i(z_req_valid), .req_ready_o(z_req_ready),
      .req_op_i(z_req_op), .req_addr_i(z_req_addr), .req_data_i(z_req_data),
      .rsp_valid_o(z_rsp_valid), .rsp_ready_i(z_rsp_ready),
      .rsp_status_o(z_rsp_status), .rsp_data_o(z_rsp_data), .regs_o(z_regs)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Full RSP_LAT=1 transaction: accept, one idle cycle, response, handshake.
   task automatic txn(input string tag, input logic [1:0] op, input logic [6:0] addr,
                      input logic [31:0] data, input logic [1:0] exp_st, input logic [31:0] exp_data);
      req_op = op; req_addr = addr; req_data = data; req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      chk({tag, "_accepted"}, {127'd0, req_ready}, 128'd0);
      chk({tag, "_wait"}, {127'd0, rsp_valid}, 128'd0);
      @(negedge clk);
      chk({tag, "_valid"}, {127'd0, rsp_valid}, 128'd1);
      chk({tag, "_status"}, {126'd0, rsp_status}, {126'd0, exp_st});
      chk({tag, "_data"}, {96'd0, rsp_data}, {96'd0, exp_data});
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk({tag, "_idle"}, {126'd0, req_ready, rsp_valid}, 128'd2);
      $display("txn %s op=%0d addr=%0d status=%0d data=%h", tag, op, addr, exp_st, exp_data);
   endtask

   initial begin
      rst_n = 1'b0;
      req_valid = 1'b0; req_op = 2'd0; req_addr = '0; req_data = '0; rsp_ready = 1'b0;
      z_req_valid = 1'b0; z_req_op = 2'd0; z_req_addr = '0; z_req_data = '0; z_rsp_ready = 1'b0;

      // Reset and idle
      @(negedge clk);
      chk("rst_ready", {127'd0, req_ready}, 128'd1);
      chk("rst_outputs", {93'd0, rsp_valid, rsp_status, rsp_data}, 128'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("idle_regs", regs, {4{32'd10}});
      chk("idle_ready", {127'd0, req_ready}, 128'd1);
      chk("idle_valid", {127'd0, rsp_valid}, 128'd0);
      $display("txn reset done regs=%h", regs);

      // rsp_ready in IDLE is ignored
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("idle_rsp_ready_ignored", {126'd0, req_ready, rsp_valid}, 128'd2);

      txn("rd2", 2'd1, 7'd2, 32'd0, 2'd0, 32'd10);
      txn("wr1", 2'd2, 7'd1, 32'hDEADBEEF, 2'd0, 32'd0);
      chk("wr1_regs_hi", {96'd0, regs[63:32]}, {96'd0, 32'hDEADBEEF});
      txn("rd1", 2'd1, 7'd1, 32'd0, 2'd0, 32'hDEADBEEF);
      txn("wr4", 2'd2, 7'd4, 32'h12345678, 2'd2, 32'd0);
      chk("wr4_regs", regs, {32'd10, 32'd10, 32'hDEADBEEF, 32'd10});
      txn("rsvd", 2'd3, 7'd0, 32'h99, 2'd2, 32'd0);
      chk("rsvd_regs", regs, {32'd10, 32'd10, 32'hDEADBEEF, 32'd10});
      txn("rd_hi_alias", 2'd1, 7'd66, 32'd0, 2'd2, 32'd0);
      txn("nop", 2'd0, 7'd0, 32'd0, 2'd0, 32'd0);

      // Stalled response; a request offered meanwhile must be ignored
      req_op = 2'd1; req_addr = 7'd3; req_valid = 1'b1;
      @(negedge clk);
      req_op = 2'd2; req_addr = 7'd0; req_data = 32'h77;
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         chk("stall_valid", {127'd0, rsp_valid}, 128'd1);
         chk("stall_rsp", {94'd0, rsp_status, rsp_data}, {94'd0, 2'd0, 32'd10});
         chk("stall_not_ready", {127'd0, req_ready}, 128'd0);
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("stall_done_idle", {126'd0, req_ready, rsp_valid}, 128'd2);
      chk("stall_req_ignored", regs[31:0], 128'd10);
      $display("txn stall read addr=3 data=%h", 32'd10);
      @(negedge clk);
      req_valid = 1'b0;
      chk("after_done_accept", {127'd0, req_ready}, 128'd0);
      @(negedge clk);
      chk("wr0_valid", {127'd0, rsp_valid}, 128'd1);
      chk("wr0_reg", {96'd0, regs[31:0]}, {96'd0, 32'h77});
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      $display("txn wr0 data=%h", 32'h77);

      // Zero-latency instance
      z_req_op = 2'd1; z_req_addr = 7'd0; z_req_valid = 1'b1;
      @(negedge clk);
      z_req_valid = 1'b0;
      chk("lat0_valid", {127'd0, z_rsp_valid}, 128'd1);
      chk("lat0_rsp", {94'd0, z_rsp_status, z_rsp_data}, {94'd0, 2'd0, 32'd10});
      z_rsp_ready = 1'b1;
      @(negedge clk);
      z_rsp_ready = 1'b0;
      chk("lat0_idle", {126'd0, z_req_ready, z_rsp_valid}, 128'd2);
      $display("txn lat0 read addr=0 data=%h", z_rsp_data);

      // Reset during WAIT of a write aborts it
      req_op = 2'd2; req_addr = 7'd0; req_data = 32'd5; req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      chk("abort_in_wait", {126'd0, req_ready, rsp_valid}, 128'd0);
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort_no_rsp", {127'd0, rsp_valid}, 128'd0);
      chk("abort_reg0", {96'd0, regs[31:0]}, {96'd0, 32'd10});
      rst_n = 1'b1;
      req_op = 2'd1; req_addr = 7'd0; req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      chk("first_edge_accept", {126'd0, req_ready, rsp_valid}, 128'd0);
      @(negedge clk);
      chk("post_rst_rsp", {93'd0, rsp_valid, rsp_status, rsp_data}, {93'd0, 1'b1, 2'd0, 32'd10});
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      $display("txn abort+reread reg0=%h", regs[31:0]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dmi_stub.md
DMI_STUB -- requirements
Module: dmi_stub

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameters, one per line: name, default, meaning:
  DATA_W     32      register and data width, 8..64
  ADDR_W     7       request address width
  NUM_REGS   4       number of implemented registers, 1..2**ADDR_W
  RESET_VAL  32'd10  reset value of every register, zero-extended or truncated to DATA_W
  RSP_LAT    1       idle cycles between request acceptance and response valid, 0..15
REQ-003 Ports, one per line: name, direction, width, meaning:
  clk_i        in   1                  clock
  rst_ni       in   1                  async active-low reset
  req_valid_i  in   1                  request valid
  req_ready_o  out  1                  request ready
  req_op_i     in   2                  op_e: NOP=0, READ=1, WRITE=2, RSVD=3
  req_addr_i   in   ADDR_W             register index
  req_data_i   in   DATA_W             write data
  rsp_valid_o  out  1                  response valid
  rsp_ready_i  in   1                  response ready
  rsp_status_o out  2                  status_e: OK=0, FAILED=2
  rsp_data_o   out  DATA_W             read data, else 0
  regs_o       out  NUM_REGS*DATA_W    all registers, reg k at bits [k*DATA_W +: DATA_W]

Function
REQ-004 The FSM SHALL have states IDLE, WAIT and RESP; only one transaction SHALL be outstanding.
REQ-005 req_ready_o SHALL be 1 only in IDLE, and a request SHALL be accepted on a cycle with req_valid_i && req_ready_o.
REQ-006 On acceptance, op, addr and data SHALL be captured, and the FSM SHALL go to WAIT with the counter loaded to RSP_LAT-1, or go directly to RESP when RSP_LAT=0.
REQ-007 In WAIT the counter SHALL decrement each cycle, and the FSM SHALL go to RESP on the cycle after the counter reads 0.
REQ-008 Response latency, from the acceptance edge to the first rsp_valid_o=1 edge, SHALL be exactly RSP_LAT+1 cycles.
REQ-009 In RESP, rsp_valid_o SHALL be 1 and rsp_status_o/rsp_data_o SHALL be held stable until rsp_ready_i=1; the FSM SHALL then return to IDLE.
REQ-010 A new request SHALL NOT be accepted in the same cycle a response completes; the earliest next acceptance SHALL be one cycle later.
REQ-011 WRITE with addr<NUM_REGS SHALL update the register on the cycle the FSM enters RESP and SHALL respond OK with data 0.
REQ-012 READ with addr<NUM_REGS SHALL respond OK with the register value sampled on RESP entry.
REQ-013 NOP SHALL respond OK with data 0.
REQ-014 RSVD, or addr>=NUM_REGS, SHALL respond FAILED with data 0 and SHALL modify no register.
REQ-015 rsp_ready_i asserted outside RESP SHALL be ignored, and req_* inputs outside IDLE SHALL be ignored.
REQ-016 regs_o SHALL reflect register contents combinationally from the flops, with no added latency.
REQ-017 Address compare SHALL use full ADDR_W width, with no aliasing.

Reset
REQ-018 While rst_ni=0: FSM=IDLE, counter=0, every register=RESET_VAL, req_ready_o=1, rsp_valid_o=0, rsp_status_o=0, rsp_data_o=0.
REQ-019 Reset asserted mid-transaction SHALL abort it without a response, and a pending WRITE SHALL NOT take effect.
REQ-020 The first request SHALL be accepted on the first clock edge after rst_ni deasserts.

Structure
REQ-021 Package dmi_stub_pkg SHALL hold op_e, status_e and the FSM state enum.
REQ-022 Register storage with its write port SHALL be sub-module dmi_stub_regfile (params DATA_W, NUM_REGS, RESET_VAL), and the FSM and latency counter SHALL stay in dmi_stub.

Verification
REQ-023 Reset, then idle 3 cycles -> regs_o = {4{32'd10}}, req_ready_o=1, rsp_valid_o=0.
REQ-024 RSP_LAT=1: READ addr 2 -> rsp_valid_o on 2nd edge after acceptance, status OK, data 32'd10.
REQ-025 WRITE addr 1 data 32'hDEADBEEF, then READ addr 1 -> OK, data 32'hDEADBEEF, and regs_o bits [63:32] = 32'hDEADBEEF.
REQ-026 WRITE addr 4 and RSVD op -> status FAILED, data 0, regs_o unchanged; RSP_LAT=0 READ -> valid 1 cycle after acceptance.
REQ-027 Hold rsp_ready_i=0 for 5 cycles -> response stable and req_ready_o=0 throughout; pulse ready -> IDLE next cycle.
REQ-028 Assert rst_ni low during WAIT of WRITE addr 0 data 5 -> no response, reg0 = 32'd10 after reset.
